pio_txf: RTL and testbench
==========================

PIO_TXF -- requirements
Module: pio_txf

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter DEPTH, default 4, unjoined entries; joined depth is 2*DEPTH.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 push  in  1  one-cycle strobe from pio_regs on a write to SMn TXF offset.
REQ-006 push_data  in  DW  write data accompanying push.
REQ-007 pop  in  1  pull request from state machine.
REQ-008 pop_data  out  DW  head entry, show-ahead.
REQ-009 join  in  1  SHIFTCTRL FJOIN_TX; 1 selects depth 2*DEPTH.
REQ-010 full  out  1  level equals active depth.
REQ-011 empty  out  1  level equals 0.
REQ-012 level  out  $clog2(2*DEPTH)+1  occupied entries, for FLEVEL.
REQ-013 txover  out  1  sticky overflow flag, for FDEBUG.
REQ-014 txstall  out  1  sticky pop-while-empty flag, for FDEBUG.
REQ-015 over_clr, stall_clr  in  1 each  write-1-to-clear strobes from FDEBUG write.

Function
REQ-016 Storage SHALL be 2*DEPTH x DW; write and read pointers wrap modulo active depth.
REQ-017 push with full=0 SHALL write push_data at write pointer; level +1 next cycle.
REQ-018 pop with empty=0 SHALL advance read pointer; level -1 next cycle.
REQ-019 push and pop together, full=0, empty=0: both occur, level unchanged.
REQ-020 push and pop together when full=1: pop occurs, push accepted, level unchanged, txover not set.
REQ-021 push and pop together when empty=1: push accepted, pop ignored (no bypass), txstall set, level becomes 1.
REQ-022 push alone when full=1 SHALL drop data, leave storage unchanged, set txover.
REQ-023 pop alone when empty=1 SHALL leave pointers unchanged and set txstall.
REQ-024 pop_data SHALL equal the head entry combinationally; when empty it holds the last written value of the head slot (undefined contents not permitted after reset: 0).
REQ-025 full, empty, level SHALL be registered-state derived, valid the cycle after the event, no combinational path from push/pop.
REQ-026 A change of join between cycles SHALL flush: pointers and level to 0 on the next edge; push/pop that cycle are ignored; sticky flags unaffected.
REQ-027 Sticky flags: set condition has priority over same-cycle clear; clear strobe otherwise zeros flag next edge.
REQ-028 Latency push to visible at pop_data when empty: 1 cycle.

Reset
REQ-029 On reset low, asynchronously: pointers 0, level 0, empty=1, full=0, txover=0, txstall=0, storage 0, pop_data 0.
REQ-030 Reset asserted mid-operation SHALL discard all contents; first push after release behaves as on empty FIFO.
REQ-031 Captured join value SHALL reset to 0.

Structure
REQ-032 Shared package bob SHALL hold TXF_DEPTH (4), TXF_DEPTH_JOINED (8), TXF_LVL_W, and FDEBUG TXOVER/TXSTALL bit positions per SM.
REQ-033 One sub-module pio_fifo_mem (2*DEPTH x DW, one write port, one async read port) SHALL hold storage; pointer/flag logic stays in pio_txf.
REQ-034 Four instances (SM0..SM3) SHALL be instantiated beside pio_regs; no bus logic inside pio_txf.

Verification
REQ-035 Reset, then 4 pushes 0x11,0x22,0x33,0x44 -> full=1, level=4, pop_data=0x11; 4 pops return 0x11..0x44 in order, then empty=1.
REQ-036 Full (join=0), push 0xDEAD -> txover=1, level=4, next pops return original 4 values; over_clr -> txover=0.
REQ-037 Empty, pop -> txstall=1, level=0; pop and push 0x55 same cycle on empty -> level=1, pop_data=0x55.
REQ-038 join=1, 8 pushes 0..7 -> full only after 8th, level=8; toggle join to 0 -> level=0, empty=1.
REQ-039 Full, simultaneous push 0x99 and pop -> level=4, txover=0, 0x99 emerges 4th.
REQ-040 Reset low with level=3 -> immediately level=0, empty=1, flags 0; 10000 random push/pop cycles vs reference queue model, zero mismatches.

Source files
------------

// File: rtl/pio_txf_pkg.sv
// Shared constants for the PIO TX FIFOs: depths, level width and FDEBUG bit map.
package bob;

    localparam int TXF_DEPTH        = 4;
    localparam int TXF_DEPTH_JOINED = 2 * TXF_DEPTH;
    localparam int TXF_LVL_W        = $clog2(TXF_DEPTH_JOINED) + 1;
    localparam int NUM_SM           = 4;

    // FDEBUG layout: TXSTALL in [27:24], TXOVER in [19:16], one bit per SM.
    localparam int FDEBUG_TXSTALL_LSB = 24;
    localparam int FDEBUG_TXOVER_LSB  = 16;

    function automatic int fdebug_txstall_bit(input int sm);
        return FDEBUG_TXSTALL_LSB + sm;
    endfunction

    function automatic int fdebug_txover_bit(input int sm);
        return FDEBUG_TXOVER_LSB + sm;
    endfunction

endpackage

// File: rtl/pio_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, cleared on reset.
module pio_fifo_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(2 * DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2*DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2 * DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pio_txf.sv
// PIO TX FIFO for one state machine: pointers, level, sticky debug flags and join/flush control.
module pio_txf
    import bob::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = TXF_DEPTH,
    parameter int PW    = $clog2(2 * DEPTH),
    parameter int LW    = $clog2(2 * DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] pop_data,
    input  logic          join_tx,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level,
    output logic          txover,
    output logic          txstall,
    input  logic          over_clr,
    input  logic          stall_clr
);

    logic          join_q;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] depth_act, last_idx;
    logic          flush, do_push, do_pop, over_set, stall_set;

    assign depth_act = join_q ? LW'(2 * DEPTH) : LW'(DEPTH);
    assign last_idx  = depth_act - LW'(1);
    assign full      = (level == depth_act);
    assign empty     = (level == '0);

    // Any change of join empties the FIFO; traffic in that cycle is discarded.
    assign flush     = (join_tx != join_q);
    assign do_pop    = pop && !empty && !flush;
    assign do_push   = push && !flush && (!full || pop);
    assign over_set  = push && full && !pop && !flush;
    assign stall_set = pop && empty && !flush;

    pio_fifo_mem #(.DW(DW), .DEPTH(DEPTH), .AW(PW)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (push_data),
        .raddr (rd_ptr),
        .rdata (pop_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            join_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            join_q <= join_tx;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= ({1'b0, wr_ptr} == last_idx) ? '0 : wr_ptr + PW'(1);
                end
                if (do_pop) begin
                    rd_ptr <= ({1'b0, rd_ptr} == last_idx) ? '0 : rd_ptr + PW'(1);
                end
                case ({do_push, do_pop})
                    2'b10:   level <= level + LW'(1);
                    2'b01:   level <= level - LW'(1);
                    default: level <= level;
                endcase
            end
        end
    end

    // Set wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            txover  <= 1'b0;
            txstall <= 1'b0;
        end else begin
            if (over_set)       txover <= 1'b1;
            else if (over_clr)  txover <= 1'b0;
            if (stall_set)      txstall <= 1'b1;
            else if (stall_clr) txstall <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pio_txf.sv
// Directed and randomized checks of pio_txf against hand-computed values and a queue model.
module tb_pio_txf;

    localparam int DW = 32;
    localparam int DEPTH = 4;
    localparam int LW = $clog2(2 * DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] pop_data;
    logic          join_tx = 1'b0;
    logic          full, empty, txover, txstall;
    logic [LW-1:0] level;
    logic          over_clr = 1'b0;
    logic          stall_clr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    pio_txf #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (pop_data),
        .join_tx   (join_tx),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .txover    (txover),
        .txstall   (txstall),
        .over_clr  (over_clr),
        .stall_clr (stall_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, then sample 1 time unit after the edge.
    task automatic cyc(input logic p, input logic [31:0] d, input logic q);
        push = p;
        push_data = d;
        pop = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        over_clr = 1'b0;
        stall_clr = 1'b0;
    endtask

    logic [31:0] vals [4];
    logic [31:0] model_q [$];
    logic        p, q;
    logic [31:0] d;
    logic        ov_model;

    initial begin
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        #12;
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_txover", 32'(txover), 0);
        chk("rst_txstall", 32'(txstall), 0);
        chk("rst_pop_data", pop_data, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Fill and drain
        for (int i = 0; i < 4; i++) cyc(1, vals[i], 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 4);
        chk("fill_head", pop_data, 32'h11);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", pop_data, vals[i]);
            cyc(0, 0, 1);
        end
        chk("drain_empty", 32'(empty), 1);

        // Overflow while full
        for (int i = 0; i < 4; i++) cyc(1, vals[i], 0);
        cyc(1, 32'hDEAD, 0);
        chk("ovf_txover", 32'(txover), 1);
        chk("ovf_level", 32'(level), 4);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_data", pop_data, vals[i]);
            cyc(0, 0, 1);
        end
        over_clr = 1'b1;
        cyc(0, 0, 0);
        chk("ovf_clr", 32'(txover), 0);

        // Stall on empty, then push+pop on empty
        cyc(0, 0, 1);
        chk("stall_set", 32'(txstall), 1);
        chk("stall_level", 32'(level), 0);
        stall_clr = 1'b1;
        cyc(0, 0, 1);
        chk("stall_prio", 32'(txstall), 1);
        cyc(1, 32'h55, 1);
        chk("pp_empty_level", 32'(level), 1);
        chk("pp_empty_data", pop_data, 32'h55);
        stall_clr = 1'b1;
        cyc(0, 0, 0);
        chk("stall_clr", 32'(txstall), 0);
        cyc(0, 0, 1);
        chk("pp_empty_drain", 32'(empty), 1);

        // Joined depth, then flush on join change
        join_tx = 1'b1;
        cyc(1, 32'hFF, 0);
        chk("join_flush_ignore", 32'(level), 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 32'(i), 0);
            if (i == 6) chk("join_not_full7", 32'(full), 0);
        end
        chk("join_full8", 32'(full), 1);
        chk("join_level8", 32'(level), 8);
        chk("join_head", pop_data, 0);
        join_tx = 1'b0;
        cyc(0, 0, 0);
        chk("unjoin_level", 32'(level), 0);
        chk("unjoin_empty", 32'(empty), 1);

        // Full with simultaneous push+pop
        for (int i = 0; i < 4; i++) cyc(1, 32'hA0 + 32'(i), 0);
        cyc(1, 32'h99, 1);
        chk("fpp_level", 32'(level), 4);
        chk("fpp_txover", 32'(txover), 0);
        for (int i = 0; i < 4; i++) begin
            chk("fpp_data", pop_data, (i == 3) ? 32'h99 : 32'hA1 + 32'(i));
            cyc(0, 0, 1);
        end

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(1, 32'hC0 + 32'(i), 0);
        cyc(0, 0, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_flags", {30'b0, txover, txstall}, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        cyc(1, 32'h77, 0);
        chk("arst_push_level", 32'(level), 1);
        chk("arst_push_data", pop_data, 32'h77);
        cyc(0, 0, 1);

        // Randomized traffic against a queue model
        ov_model = 1'b0;
        model_q.delete();
        for (int n = 0; n < 10000; n++) begin
            p = 1'($urandom_range(0, 1));
            q = 1'($urandom_range(0, 1));
            d = $urandom;
            if (p && model_q.size() == 4 && !q) ov_model = 1'b1;
            if (q && model_q.size() != 0) void'(model_q.pop_front());
            if (p && (model_q.size() < 4)) model_q.push_back(d);
            cyc(p, d, q);
            chk("rnd_level", 32'(level), 32'(model_q.size()));
            if (model_q.size() != 0) chk("rnd_data", pop_data, model_q[0]);
        end
        chk("rnd_txover", 32'(txover), 32'(ov_model));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
